cpu_debug_display: RTL and testbench

//  Board-level front end for the single-cycle CPU; sits outside the CPU core.
//  - Debounces the manual step button and produces the CPU clock.
//  - Consumes the CPU's debug outputs (PC, register ports, ALU result, write-back data).
//  - Time-multiplexes a selected 16-bit view onto a 4-digit, common-anode 7-segment display.

---
 rtl/cpu_debug_display.sv | 135 +++++++++++++
 tb/tb_cpu_debug_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_display.sv
// rtl/cpu_debug_display.sv - step-button debouncer and 4-digit 7-segment debug view for the single-cycle CPU
//
// Purpose:
//   Debounces the manual step button into the CPU clock and time-multiplexes a
//   selected 16-bit debug view onto a 4-digit common-anode 7-segment display.
// Ports:
//   clk, reset          board clock, asynchronous active-high reset
//   btn_step            raw bouncy step button (1 = pressed)
//   sel                 view select: 00 PC, 01 rs, 10 rt, 11 ALU/write-back
//   pc_cur .. db_data   CPU debug outputs
//   cpu_clk             debounced button level, drives the CPU clock
//   step_pulse          one-clk pulse per accepted press
//   an                  active-low digit enables, an[3] = leftmost
//   seg                 active-low segments, seg[7] = dp, seg[6:0] = g..a
module cpu_debug_display #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_step,
  input  logic [1:0]  sel,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_next,
  input  logic [4:0]  rs_addr,
  input  logic [31:0] rs_data,
  input  logic [4:0]  rt_addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] db_data,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic          sync_meta;
  logic          sync;
  logic          db_level;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [15:0]   snapshot;
  logic [15:0]   view;

  // Only the low byte of each 32-bit debug bus is displayed.
  logic unused_bits;
  assign unused_bits = ^{pc_cur[31:8], pc_next[31:8], rs_data[31:8],
                         rt_data[31:8], alu_result[31:8], db_data[31:8]};

  always_comb begin
    view = 16'h0000;
    case (sel)
      2'b00: view = {pc_cur[7:0], pc_next[7:0]};
      2'b01: view = {3'b000, rs_addr, rs_data[7:0]};
      2'b10: view = {3'b000, rt_addr, rt_data[7:0]};
      default: view = {alu_result[7:0], db_data[7:0]};
    endcase
  end

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  assign cpu_clk = db_level;

  // Debounce: the synchronized level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive samples before it is taken; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync       <= 1'b0;
      db_level   <= 1'b0;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync_meta  <= btn_step;
      sync       <= sync_meta;
      step_pulse <= 1'b0;
      if (sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level   <= sync;
        db_cnt     <= '0;
        step_pulse <= sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Scan: the snapshot is only refreshed as idx wraps 3->0 so a frame never mixes two views.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      snapshot <= 16'h0000;
      an       <= 4'b1110;
      seg      <= 8'hC0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
        if (idx == 2'd3) snapshot <= view;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= hex_to_seg(snapshot[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_cpu_debug_display.sv
// tb/tb_cpu_debug_display.sv - self-checking bench for cpu_debug_display with a behavioural model
module tb_cpu_debug_display;

  localparam int D = 4;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_step;
  logic [1:0]  sel;
  logic [31:0] pc_cur, pc_next, rs_data, rt_data, alu_result, db_data;
  logic [4:0]  rs_addr, rt_addr;
  logic        cpu_clk, step_pulse;
  logic [3:0]  an;
  logic [7:0]  seg;

  cpu_debug_display #(.DEBOUNCE_CYCLES(D), .SCAN_DIV(S)) dut (
    .clk(clk), .reset(reset), .btn_step(btn_step), .sel(sel),
    .pc_cur(pc_cur), .pc_next(pc_next), .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_data(rt_data), .alu_result(alu_result), .db_data(db_data),
    .cpu_clk(cpu_clk), .step_pulse(step_pulse), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: edges since reset release, displayed snapshot, accepted level,
  // and the history of button values sampled at each edge.
  int          k;
  logic [15:0] m_snap;
  logic        m_level;
  bit          hist[$];
  int          pulses;
  int          last_pulse_k;
  int          last_fall_k;
  logic        prev_cpu;
  logic [7:0]  seg_at [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] view_word();
    case (sel)
      2'b00: return {pc_cur[7:0], pc_next[7:0]};
      2'b01: return {3'b000, rs_addr, rs_data[7:0]};
      2'b10: return {3'b000, rt_addr, rt_data[7:0]};
      default: return {alu_result[7:0], db_data[7:0]};
    endcase
  endfunction

  task automatic model_reset();
    k = 0;
    m_snap = 16'h0000;
    m_level = 1'b0;
    prev_cpu = 1'b0;
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_an"}, {28'd0, an}, 32'hE);
    chk({tag, "_seg"}, {24'd0, seg}, 32'hC0);
    chk({tag, "_cpu_clk"}, {31'd0, cpu_clk}, 32'd0);
    chk({tag, "_pulse"}, {31'd0, step_pulse}, 32'd0);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    check_reset_values("rst_now");
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_reset_values("rst_hold");
    end
    reset = 1'b0;
    model_reset();
  endtask

  // One clock edge: advance the model from the rules, then compare all outputs.
  task automatic cycle();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       flip;
    logic       e_pulse;
    int         sidx;
    int         n;
    @(posedge clk);
    k++;
    sidx  = ((k - 1) / S) % 4;
    e_an  = ~(4'b0001 << sidx);
    e_seg = hex_tab[(m_snap >> (4 * sidx)) & 16'hF];
    if (k % (4 * S) == 0) m_snap = view_word();
    hist.push_back(btn_step);
    // Level flips once the samples 2..D+1 edges back all disagree with it.
    n = hist.size();
    flip = 1'b1;
    for (int i = 2; i <= D + 1; i++) if (hist[n - 1 - i] == m_level) flip = 1'b0;
    e_pulse = flip && !m_level;
    if (flip) m_level = !m_level;
    if (hist.size() > 64) void'(hist.pop_front());
    #1;
    chk("cpu_clk", {31'd0, cpu_clk}, {31'd0, m_level});
    chk("step_pulse", {31'd0, step_pulse}, {31'd0, e_pulse});
    chk("an", {28'd0, an}, {28'd0, e_an});
    chk("seg", {24'd0, seg}, {24'd0, e_seg});
    if (step_pulse) begin pulses++; last_pulse_k = k; end
    if (prev_cpu && !cpu_clk) last_fall_k = k;
    prev_cpu = cpu_clk;
    if (k < 64) seg_at[k] = seg;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int k0, p0;
  logic [7:0] exp4 [4];
  logic [7:0] expf [8];

  initial begin
    reset = 1'b1; btn_step = 1'b0; sel = 2'b00;
    pc_cur = $urandom; pc_next = $urandom; rs_addr = 5'($urandom); rs_data = $urandom;
    rt_addr = 5'($urandom); rt_data = $urandom; alu_result = $urandom; db_data = $urandom;
    pulses = 0; last_pulse_k = -1; last_fall_k = -1;
    model_reset();

    // 1: reset values held while reset is high
    @(posedge clk);
    do_reset(3);

    // 2: clean press, then release
    run(2);
    btn_step = 1'b1; k0 = k; p0 = pulses;
    for (int i = 0; i < 20 && pulses == p0; i++) cycle();
    chk("press_latency", last_pulse_k - k0, 6);
    chk("press_one_pulse", pulses - p0, 1);
    run(5);
    chk("hold_one_step", pulses - p0, 1);
    btn_step = 1'b0; k0 = k; last_fall_k = -1;
    for (int i = 0; i < 20 && last_fall_k < 0; i++) cycle();
    chk("release_latency", last_fall_k - k0, 6);
    chk("release_no_pulse", pulses - p0, 1);

    // 3: bounce every 2 clks for 20 clks, never accepted
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      btn_step = ((i / 2) % 2 == 0);
      cycle();
    end
    btn_step = 1'b0;
    run(10);
    chk("bounce_no_pulse", pulses - p0, 0);
    chk("bounce_level", {31'd0, cpu_clk}, 32'd0);

    // 4: PC view 14/18 -> digits 1,4,1,8
    do_reset(1);
    sel = 2'b00; pc_cur = 32'h0000_0014; pc_next = 32'h0000_0018;
    run(24);
    exp4 = '{8'h80, 8'hF9, 8'h99, 8'hF9};
    for (int n = 0; n < 4; n++) chk("pc_digit", {24'd0, seg_at[13 + 3 * n]}, {24'd0, exp4[n]});

    // 5: ALU/write-back view, sel switched to rs mid-frame
    do_reset(1);
    sel = 2'b11; alu_result = 32'h1234_56AB; db_data = 32'h9876_54CD;
    rs_addr = 5'h12; rs_data = 32'hFFFF_FF34;
    run(15);
    sel = 2'b01;
    run(21);
    expf = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int n = 0; n < 8; n++) chk("frame_digit", {24'd0, seg_at[13 + 3 * n]}, {24'd0, expf[n]});

    // 6: reset while pressed at scan idx 2, button held through release
    do_reset(1);
    btn_step = 1'b1;
    run(7);
    chk("pre_rst_level", {31'd0, cpu_clk}, 32'd1);
    do_reset(2);
    p0 = pulses; k0 = k;
    for (int i = 0; i < 20 && pulses == p0; i++) cycle();
    chk("held_thru_rst_latency", last_pulse_k - k0, 6);
    run(4);
    chk("held_thru_rst_one", pulses - p0, 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        pc_cur = $urandom; pc_next = $urandom; rs_addr = 5'($urandom); rs_data = $urandom;
        rt_addr = 5'($urandom); rt_data = $urandom; alu_result = $urandom; db_data = $urandom;
      end
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(0, 2));
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
